// File: rtl/serial_rx_fifo_pkg.sv
// ----------------------------------------------------------------------------
// serial_rx_fifo_pkg
// Shared defaults for the serial receive path (byte width, FIFO geometry,
// clock/baud defaults common to serial_rx/serial_tx) and the occupancy-update
// encoding used by the receive FIFO control.
// ----------------------------------------------------------------------------
package serial_rx_fifo_pkg;

    localparam int unsigned SRF_DATA_WIDTH  = 8;
    localparam int unsigned SRF_DEPTH_LOG2  = 4;
    localparam int unsigned SRF_ALMOST_FULL = 12;
    localparam int unsigned SRF_CLK_FREQ    = 50_000_000;
    localparam int unsigned SRF_BAUD_RATE   = 115_200;

    // How the occupancy counter moves in a given cycle.
    typedef enum logic [1:0] {
        CNT_HOLD = 2'd0,
        CNT_INC  = 2'd1,
        CNT_DEC  = 2'd2
    } cnt_op_e;

endpackage

// File: rtl/serial_rx_fifo_if.sv
// ----------------------------------------------------------------------------
// serial_rx_fifo_if
// Byte stream into and out of the receive FIFO.
//   i_wr / i_data  : one-cycle write strobe and byte from serial_rx
//   o_valid/o_data : head-of-FIFO byte presented to the consumer
//   i_rd           : consumer pop
// Modports: master = producer/consumer side, slave = FIFO side.
// ----------------------------------------------------------------------------
interface serial_rx_fifo_if #(
    parameter int unsigned DATA_WIDTH = serial_rx_fifo_pkg::SRF_DATA_WIDTH
);
    logic                  i_wr;
    logic [DATA_WIDTH-1:0] i_data;
    logic                  o_valid;
    logic [DATA_WIDTH-1:0] o_data;
    logic                  i_rd;

    modport master (
        output i_wr,
        output i_data,
        output i_rd,
        input  o_valid,
        input  o_data
    );

    modport slave (
        input  i_wr,
        input  i_data,
        input  i_rd,
        output o_valid,
        output o_data
    );
endinterface

// File: rtl/serial_rx_fifo_ram.sv
// ----------------------------------------------------------------------------
// fifo_ram
// DEPTH x DATA_WIDTH storage: one synchronous write port, one asynchronous
// read port (maps onto distributed/LUT RAM). Contents are not reset.
//   i_clk   : clock
//   i_we    : write enable
//   i_waddr : write address
//   i_wdata : write data
//   i_raddr : read address
//   o_rdata : read data (combinational from i_raddr)
// ----------------------------------------------------------------------------
module fifo_ram
    import serial_rx_fifo_pkg::*;
#(
    parameter int unsigned DATA_WIDTH = SRF_DATA_WIDTH,
    parameter int unsigned ADDR_WIDTH = SRF_DEPTH_LOG2
) (
    input  logic                  i_clk,
    input  logic                  i_we,
    input  logic [ADDR_WIDTH-1:0] i_waddr,
    input  logic [DATA_WIDTH-1:0] i_wdata,
    input  logic [ADDR_WIDTH-1:0] i_raddr,
    output logic [DATA_WIDTH-1:0] o_rdata
);
    logic [DATA_WIDTH-1:0] r_mem [0:(1 << ADDR_WIDTH)-1];

    always_ff @(posedge i_clk) begin
        if (i_we) begin
            r_mem[i_waddr] <= i_wdata;
        end
    end

    assign o_rdata = r_mem[i_raddr];
endmodule

// File: rtl/serial_rx_fifo.sv
// ----------------------------------------------------------------------------
// serial_rx_fifo
// Receive buffer behind serial_rx. Never stalls its input: bytes arriving
// while full are dropped and flagged by a sticky overrun. Flow control (RTS)
// is raised early at ALMOST_FULL so in-flight bytes still fit.
//   i_clk          : clock
//   i_rst_n        : synchronous reset, active-low (discards buffered bytes)
//   io_bus         : write strobe in, valid/data/rd consumer handshake
//   o_count        : occupancy 0..2**DEPTH_LOG2
//   o_full         : count == depth
//   o_almost_full  : count >= ALMOST_FULL
//   o_rts_n        : 0 = sender may transmit, 1 = hold off
//   o_overrun      : sticky, a byte was dropped on full
//   i_clr_overrun  : pulse to clear o_overrun (a simultaneous drop wins)
// ----------------------------------------------------------------------------
module serial_rx_fifo
    import serial_rx_fifo_pkg::*;
#(
    parameter int unsigned DATA_WIDTH  = SRF_DATA_WIDTH,
    parameter int unsigned DEPTH_LOG2  = SRF_DEPTH_LOG2,
    parameter int unsigned ALMOST_FULL = SRF_ALMOST_FULL
) (
    input  logic                  i_clk,
    input  logic                  i_rst_n,
    serial_rx_fifo_if.slave       io_bus,
    output logic [DEPTH_LOG2:0]   o_count,
    output logic                  o_full,
    output logic                  o_almost_full,
    output logic                  o_rts_n,
    output logic                  o_overrun,
    input  logic                  i_clr_overrun
);
    localparam int unsigned CW    = DEPTH_LOG2 + 1;
    localparam int unsigned DEPTH = 1 << DEPTH_LOG2;
    localparam logic [CW-1:0] C_DEPTH = CW'(DEPTH);
    localparam logic [CW-1:0] C_AF    = CW'(ALMOST_FULL);

    logic [DEPTH_LOG2-1:0] r_wr_ptr;
    logic [DEPTH_LOG2-1:0] r_rd_ptr;
    logic [CW-1:0]         r_count;
    logic                  r_valid;
    logic                  r_full;
    logic                  r_almost_full;
    logic                  r_rts_n;
    logic                  r_overrun;

    logic                  w_rd_ok;
    logic                  w_wr_ok;
    logic                  w_drop;
    cnt_op_e               w_op;
    logic [CW-1:0]         w_count_nx;

    // A write into a full FIFO is still accepted when the same cycle pops the
    // head, so the slot it frees is reused immediately.
    always_comb begin
        w_rd_ok = io_bus.i_rd && r_valid;
        w_wr_ok = io_bus.i_wr && (!r_full || w_rd_ok);
        w_drop  = io_bus.i_wr && !w_wr_ok;

        w_op = CNT_HOLD;
        if (w_wr_ok && !w_rd_ok) begin
            w_op = CNT_INC;
        end else if (w_rd_ok && !w_wr_ok) begin
            w_op = CNT_DEC;
        end

        case (w_op)
            CNT_INC: w_count_nx = r_count + CW'(1);
            CNT_DEC: w_count_nx = r_count - CW'(1);
            default: w_count_nx = r_count;
        endcase
    end

    // Flags are registered from the next count so they change on the same
    // edge as o_count rather than one cycle behind it.
    always_ff @(posedge i_clk) begin
        if (!i_rst_n) begin
            r_wr_ptr      <= '0;
            r_rd_ptr      <= '0;
            r_count       <= '0;
            r_valid       <= 1'b0;
            r_full        <= 1'b0;
            r_almost_full <= 1'b0;
            r_rts_n       <= 1'b0;
            r_overrun     <= 1'b0;
        end else begin
            if (w_wr_ok) begin
                r_wr_ptr <= r_wr_ptr + DEPTH_LOG2'(1);
            end
            if (w_rd_ok) begin
                r_rd_ptr <= r_rd_ptr + DEPTH_LOG2'(1);
            end
            r_count       <= w_count_nx;
            r_valid       <= (w_count_nx != '0);
            r_full        <= (w_count_nx == C_DEPTH);
            r_almost_full <= (w_count_nx >= C_AF);
            r_rts_n       <= (w_count_nx >= C_AF);
            if (w_drop) begin
                r_overrun <= 1'b1;
            end else if (i_clr_overrun) begin
                r_overrun <= 1'b0;
            end
        end
    end

    fifo_ram #(
        .DATA_WIDTH (DATA_WIDTH),
        .ADDR_WIDTH (DEPTH_LOG2)
    ) u_ram (
        .i_clk   (i_clk),
        .i_we    (w_wr_ok),
        .i_waddr (r_wr_ptr),
        .i_wdata (io_bus.i_data),
        .i_raddr (r_rd_ptr),
        .o_rdata (io_bus.o_data)
    );

    assign io_bus.o_valid = r_valid;
    assign o_count        = r_count;
    assign o_full         = r_full;
    assign o_almost_full  = r_almost_full;
    assign o_rts_n        = r_rts_n;
    assign o_overrun      = r_overrun;
endmodule

// File: tb/tb_serial_rx_fifo.sv
// ----------------------------------------------------------------------------
// tb_serial_rx_fifo
// Self-checking bench for serial_rx_fifo: a short table of single-cycle
// vectors with fixed expectations, then scoreboarded multi-cycle sequences
// (fill/drain, overrun, full with simultaneous read/write, pointer wrap,
// mid-stream reset, slow sparse writer with no consumer).
// ----------------------------------------------------------------------------
module tb_serial_rx_fifo;
    localparam int unsigned DW = 8;
    localparam int unsigned DL = 4;
    localparam int unsigned AF = 12;
    localparam int unsigned DEPTH = 1 << DL;

    logic          clk = 1'b0;
    logic          rst_n = 1'b0;
    logic          clr_ovr = 1'b0;
    logic [DL:0]   count;
    logic          full, almost_full, rts_n, overrun;

    serial_rx_fifo_if #(.DATA_WIDTH(DW)) bus ();

    serial_rx_fifo #(
        .DATA_WIDTH  (DW),
        .DEPTH_LOG2  (DL),
        .ALMOST_FULL (AF)
    ) dut (
        .i_clk         (clk),
        .i_rst_n       (rst_n),
        .io_bus        (bus),
        .o_count       (count),
        .o_full        (full),
        .o_almost_full (almost_full),
        .o_rts_n       (rts_n),
        .o_overrun     (overrun),
        .i_clr_overrun (clr_ovr)
    );

    always #5 clk = ~clk;

    int unsigned n_pass  = 0;
    int unsigned n_total = 0;

    logic [DW-1:0] sb [$];
    logic          m_ovr;

    typedef struct {
        logic          wr;
        logic [DW-1:0] data;
        logic          rd;
        logic          exp_valid;
        logic [DL:0]   exp_count;
        logic [DW-1:0] exp_data;
    } vec_t;

    vec_t vecs [6];

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_total++;
        if (act === exp) begin
            n_pass++;
        end else begin
            $display("FAIL %s: got 0x%0h, expected 0x%0h at %0t", name, act, exp, $time);
        end
    endtask

    task automatic do_reset();
        rst_n    = 1'b0;
        bus.i_wr = 1'b0;
        bus.i_rd = 1'b0;
        bus.i_data = '0;
        clr_ovr  = 1'b0;
        @(posedge clk);
        #1;
        rst_n = 1'b1;
        sb.delete();
        m_ovr = 1'b0;
        check("rst_valid",   32'(bus.o_valid), 32'd0);
        check("rst_count",   32'(count),       32'd0);
        check("rst_full",    32'(full),        32'd0);
        check("rst_afull",   32'(almost_full), 32'd0);
        check("rst_rts_n",   32'(rts_n),       32'd0);
        check("rst_overrun", 32'(overrun),     32'd0);
    endtask

    // One clock of stimulus; the queue-based model predicts acceptance,
    // head data and flags independently of the DUT.
    task automatic step(input logic wr, input logic [DW-1:0] d, input logic rd, input logic clr);
        logic rd_ok, wr_ok;
        int   n;
        bus.i_wr   = wr;
        bus.i_data = d;
        bus.i_rd   = rd;
        clr_ovr    = clr;
        rd_ok = rd && (sb.size() > 0);
        wr_ok = wr && ((sb.size() < int'(DEPTH)) || rd_ok);
        if (rd_ok) begin
            check("rd_data", 32'(bus.o_data), 32'(sb.pop_front()));
        end
        if (wr_ok) sb.push_back(d);
        if (wr && !wr_ok) m_ovr = 1'b1;
        else if (clr)     m_ovr = 1'b0;
        @(posedge clk);
        #1;
        n = sb.size();
        check("count",   32'(count),       32'(n));
        check("valid",   32'(bus.o_valid), 32'(n != 0));
        check("full",    32'(full),        32'(n == int'(DEPTH)));
        check("afull",   32'(almost_full), 32'(n >= int'(AF)));
        check("rts_n",   32'(rts_n),       32'(n >= int'(AF)));
        check("overrun", 32'(overrun),     32'(m_ovr));
    endtask

    task automatic idle();
        step(1'b0, '0, 1'b0, 1'b0);
    endtask

    task automatic fill_seq();
        for (int unsigned i = 0; i < DEPTH; i++) step(1'b1, DW'(i), 1'b0, 1'b0);
    endtask

    task automatic drain(input int unsigned n);
        for (int unsigned i = 0; i < n; i++) step(1'b0, '0, 1'b1, 1'b0);
    endtask

    initial begin
        #1_000_000;
        $display("FAIL watchdog: simulation did not finish, got timeout expected completion");
        $fatal(1, "watchdog");
    end

    initial begin
        bus.i_wr   = 1'b0;
        bus.i_rd   = 1'b0;
        bus.i_data = '0;
        m_ovr      = 1'b0;

        //          wr    data   rd    valid count data
        vecs[0] = '{1'b1, 8'h4B, 1'b0, 1'b1, 5'd1, 8'h4B}; // single write
        vecs[1] = '{1'b0, 8'h00, 1'b1, 1'b0, 5'd0, 8'h00}; // pop it
        vecs[2] = '{1'b1, 8'h11, 1'b1, 1'b1, 5'd1, 8'h11}; // empty: write wins, read ignored
        vecs[3] = '{1'b1, 8'h22, 1'b1, 1'b1, 5'd1, 8'h22}; // simultaneous rd+wr at count 1
        vecs[4] = '{1'b0, 8'h00, 1'b1, 1'b0, 5'd0, 8'h00}; // pop last
        vecs[5] = '{1'b0, 8'h00, 1'b1, 1'b0, 5'd0, 8'h00}; // read while empty

        @(posedge clk);
        #1;
        do_reset();

        for (int unsigned i = 0; i < 6; i++) begin
            bus.i_wr   = vecs[i].wr;
            bus.i_data = vecs[i].data;
            bus.i_rd   = vecs[i].rd;
            @(posedge clk);
            #1;
            check($sformatf("vec%0d_valid", i), 32'(bus.o_valid), 32'(vecs[i].exp_valid));
            check($sformatf("vec%0d_count", i), 32'(count),       32'(vecs[i].exp_count));
            check($sformatf("vec%0d_ovr", i),   32'(overrun),     32'd0);
            if (vecs[i].exp_valid) begin
                check($sformatf("vec%0d_data", i), 32'(bus.o_data), 32'(vecs[i].exp_data));
            end
        end

        // Fill to full, then drain in order.
        do_reset();
        fill_seq();
        drain(DEPTH);

        // Overrun on full, sticky through the drain, then cleared.
        fill_seq();
        step(1'b1, 8'hAA, 1'b0, 1'b0);
        drain(DEPTH);
        check("ovr_sticky", 32'(overrun), 32'd1);
        step(1'b0, '0, 1'b0, 1'b1);
        check("ovr_cleared", 32'(overrun), 32'd0);

        // Clear coinciding with a new drop: the drop wins.
        fill_seq();
        step(1'b1, 8'hBB, 1'b0, 1'b1);
        check("ovr_set_wins", 32'(overrun), 32'd1);
        step(1'b0, '0, 1'b0, 1'b1);
        drain(DEPTH);

        // Full with simultaneous write and read: both accepted, 0x55 last.
        fill_seq();
        step(1'b1, 8'h55, 1'b1, 1'b0);
        check("full_rw_count", 32'(count),   32'd16);
        check("full_rw_ovr",   32'(overrun), 32'd0);
        drain(DEPTH);

        // Pointer wrap: three rounds of 10 writes then 10 reads.
        for (int r = 0; r < 3; r++) begin
            for (int k = 0; k < 10; k++) step(1'b1, DW'($urandom_range(0, 255)), 1'b0, 1'b0);
            drain(10);
        end
        check("wrap_end_count", 32'(count), 32'd0);

        // Reset with bytes buffered discards them.
        for (int k = 0; k < 5; k++) step(1'b1, DW'(8'hC0 + k), 1'b0, 1'b0);
        do_reset();
        step(1'b1, 8'h77, 1'b0, 1'b0);
        step(1'b0, '0, 1'b1, 1'b0);

        // Slow sparse writer, consumer never reads: 16 stored, then overrun.
        for (int k = 0; k < 20; k++) begin
            step(1'b1, 8'h4B, 1'b0, 1'b0);
            repeat (3) idle();
        end
        check("sparse_count",   32'(count),   32'd16);
        check("sparse_overrun", 32'(overrun), 32'd1);
        drain(DEPTH);

        $display("%0d/%0d checks passed", n_pass, n_total);
        $finish;
    end
endmodule
